// File: rtl/mux4_sel_reg_if.sv
// Lane-selector bus: sample side (in_valid, lanes, select, enable mask) and
// registered result side (out, out_valid, sel_changed).
//   master: drives samples, observes results (the environment).
//   slave : receives samples, drives results (the selector).
interface mux4_sel_reg_if #(
  parameter int unsigned WIDTH = 1
);
  logic               in_valid;
  logic [4*WIDTH-1:0] input_lines;
  logic [1:0]         select_lines;
  logic [3:0]         lane_enable;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               sel_changed;

  modport master (
    output in_valid, input_lines, select_lines, lane_enable,
    input  out, out_valid, sel_changed
  );

  modport slave (
    input  in_valid, input_lines, select_lines, lane_enable,
    output out, out_valid, sel_changed
  );
endinterface

// File: rtl/mux4_sel_reg.sv
// Registered 4-to-1 lane selector with per-lane saturating selection counters.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/input_lines/select_lines/lane_enable in,
//                  out/out_valid/sel_changed out (one cycle after accept)
//   cnt_rd_sel   : lane whose counter is shown on cnt_rd_data
//   cnt_rd_data  : combinational read of the selected counter
//   cnt_clr      : synchronous clear of all counters, wins over increment
module mux4_sel_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_sel_reg_if.slave      bus,
  input  logic [1:0]         cnt_rd_sel,
  output logic [CNT_W-1:0]   cnt_rd_data,
  input  logic               cnt_clr
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] lane_data;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             sel_changed_q;
  logic [1:0]       last_sel_q;
  logic [CNT_W-1:0] cnt_q [4];

  // Disabled lanes forward zeros but are still counted as selected.
  always_comb begin
    lane_data = '0;
    unique case (bus.select_lines)
      2'b00: lane_data = bus.input_lines[0*WIDTH +: WIDTH];
      2'b01: lane_data = bus.input_lines[1*WIDTH +: WIDTH];
      2'b10: lane_data = bus.input_lines[2*WIDTH +: WIDTH];
      2'b11: lane_data = bus.input_lines[3*WIDTH +: WIDTH];
      default: lane_data = '0;
    endcase
    if (!bus.lane_enable[bus.select_lines]) begin
      lane_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      sel_changed_q <= 1'b0;
      last_sel_q    <= 2'b00;
    end else if (bus.in_valid) begin
      out_q         <= lane_data;
      out_valid_q   <= 1'b1;
      sel_changed_q <= (bus.select_lines != last_sel_q);
      last_sel_q    <= bus.select_lines;
    end else begin
      out_valid_q   <= 1'b0;
      sel_changed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= '0;
        end else if (bus.in_valid && (bus.select_lines == 2'(k)) && (cnt_q[k] != CntMax)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sel_changed = sel_changed_q;
  assign cnt_rd_data     = cnt_q[cnt_rd_sel];

endmodule

// File: tb/tb_mux4_sel_reg.sv
module tb_mux4_sel_reg;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;
  localparam int          CMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cnt_rd_sel;
  logic [CW-1:0] cnt_rd_data;
  logic          cnt_clr;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  mux4_sel_reg_if #(.WIDTH(W)) bus ();

  mux4_sel_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cnt_rd_sel  (cnt_rd_sel),
    .cnt_rd_data (cnt_rd_data),
    .cnt_clr     (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after each edge.
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_chg;
  logic [1:0]   m_last;
  int           m_cnt [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   <= '0;
      m_valid <= 1'b0;
      m_chg   <= 1'b0;
      m_last  <= 2'b00;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else begin
      if (bus.in_valid) begin
        m_out   <= bus.lane_enable[bus.select_lines]
                   ? W'(bus.input_lines >> (int'(bus.select_lines) * W)) : '0;
        m_valid <= 1'b1;
        m_chg   <= (bus.select_lines != m_last);
        m_last  <= bus.select_lines;
      end else begin
        m_valid <= 1'b0;
        m_chg   <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr) m_cnt[i] <= 0;
        else if (bus.in_valid && int'(bus.select_lines) == i && m_cnt[i] < CMAX)
          m_cnt[i] <= m_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("out", 32'(bus.out), 32'(m_out));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("sel_changed", 32'(bus.sel_changed), 32'(m_chg));
      chk("cnt_rd_data", 32'(cnt_rd_data), m_cnt[cnt_rd_sel]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_cnt(input string name, input int exp);
    for (int k = 0; k < 4; k++) begin
      cnt_rd_sel = 2'(k);
      #1;
      chk(name, 32'(cnt_rd_data), exp);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.input_lines  = 16'($urandom);
      bus.select_lines = 2'($urandom);
      bus.lane_enable  = 4'($urandom);
      cnt_rd_sel       = 2'($urandom);
      cnt_clr          = ($urandom_range(0, 31) == 0);
      step();
    end
  endtask

  logic [W-1:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 4'h1; sweep_exp[1] = 4'h2; sweep_exp[2] = 4'h4; sweep_exp[3] = 4'h8;
    bus.in_valid = 1'b0; bus.input_lines = '0; bus.select_lines = 2'b00;
    bus.lane_enable = 4'h0; cnt_rd_sel = 2'b00; cnt_clr = 1'b0;

    #12;
    chk("reset out", 32'(bus.out), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset sel_changed", 32'(bus.sel_changed), 0);
    chk_all_cnt("reset cnt", 0);

    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Select sweep, two accepts per select.
    bus.input_lines = 16'h8421;
    bus.lane_enable = 4'hF;
    bus.in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 2; r++) begin
        bus.select_lines = 2'(s);
        step();
        chk("sweep out", 32'(bus.out), 32'(sweep_exp[s]));
        chk("sweep out_valid", 32'(bus.out_valid), 1);
        chk("sweep sel_changed", 32'(bus.sel_changed), (r == 0 && s != 0) ? 1 : 0);
      end
    end
    bus.in_valid = 1'b0;
    chk_all_cnt("sweep cnt", 2);

    // Disabled lane: zero data, still counted.
    bus.lane_enable = 4'b1101;
    bus.select_lines = 2'b01;
    bus.input_lines = 16'h0020;
    bus.in_valid = 1'b1;
    cnt_rd_sel = 2'b01;
    step();
    chk("disabled out", 32'(bus.out), 0);
    chk("disabled out_valid", 32'(bus.out_valid), 1);
    chk("disabled sel_changed", 32'(bus.sel_changed), 1);
    chk("disabled cnt1", 32'(cnt_rd_data), 3);

    // No accept: hold.
    bus.in_valid = 1'b0;
    bus.input_lines = 16'hFFFF;
    bus.lane_enable = 4'hF;
    for (int s = 2; s < 4; s++) begin
      bus.select_lines = 2'(s);
      step();
      chk("idle out hold", 32'(bus.out), 0);
      chk("idle out_valid", 32'(bus.out_valid), 0);
      chk("idle sel_changed", 32'(bus.sel_changed), 0);
      chk("idle cnt1", 32'(cnt_rd_data), 3);
    end

    // Saturation on lane 2: 2 + 8 accepts clamps at 7.
    bus.in_valid = 1'b1;
    bus.select_lines = 2'b10;
    cnt_rd_sel = 2'b10;
    repeat (8) step();
    chk("sat out", 32'(bus.out), 32'hF);
    chk("sat cnt2", 32'(cnt_rd_data), CMAX);

    // Clear beats a simultaneous accept.
    cnt_clr = 1'b1;
    bus.select_lines = 2'b00;
    step();
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    chk_all_cnt("clr cnt", 0);

    rand_cycles(400);

    // Asynchronous reset between edges, with a sample in flight.
    bus.in_valid = 1'b1;
    bus.input_lines = 16'hFFFF;
    bus.lane_enable = 4'hF;
    bus.select_lines = 2'b10;
    cnt_clr = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst out", 32'(bus.out), 0);
    chk("async rst out_valid", 32'(bus.out_valid), 0);
    chk("async rst sel_changed", 32'(bus.sel_changed), 0);
    chk_all_cnt("async rst cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.select_lines = 2'b11;
    step();
    chk("post rst out", 32'(bus.out), 32'hF);
    chk("post rst sel_changed", 32'(bus.sel_changed), 1);

    rand_cycles(200);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
